// File: rtl/VX_gpu_pkg.sv
// ============================================================================
// Module      : VX_gpu_pkg
// Description : Shared width helper and beat type for the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package VX_gpu_pkg;

  localparam int WB_ARB_DATAW = 64;

  // Index width for N requesters; never narrower than one bit.
  function automatic int WB_ARB_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [WB_ARB_DATAW-1:0] data;
    logic                    sop;
    logic                    eop;
  } wb_beat_t;

endpackage

`default_nettype wire

// File: rtl/wb_commit_arb_if.sv
// ============================================================================
// Module      : wb_commit_arb_if
// Description : Requester and writeback bundle of the commit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_commit_arb_if
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64
) ();

  localparam int IDX_W = WB_ARB_IDX_W(NUM_REQS);

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0][DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]            req_sop;
  logic [NUM_REQS-1:0]            req_eop;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATAW-1:0]               out_data;
  logic                           out_sop;
  logic                           out_eop;
  logic                           out_ready;
  logic [IDX_W-1:0]               out_grant_idx;

  // master is the arbiter side; slave is the requester/consumer side.
  modport master (
    input  req_valid, req_data, req_sop, req_eop, out_ready,
    output req_ready, out_valid, out_data, out_sop, out_eop, out_grant_idx
  );

  modport slave (
    output req_valid, req_data, req_sop, req_eop, out_ready,
    input  req_ready, out_valid, out_data, out_sop, out_eop, out_grant_idx
  );

endinterface

`default_nettype wire

// File: rtl/wb_rr_picker.sv
// ============================================================================
// Module      : wb_rr_picker
// Description : Combinational rotate-priority encoder starting at rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_picker
  import VX_gpu_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = WB_ARB_IDX_W(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [IDX_W-1:0]    winner,
  output logic                winner_valid
);

  int w_idx;

  // Scan from the farthest offset down so the nearest one to rr_ptr wins.
  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    w_idx        = 0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      w_idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (valid[w_idx]) begin
        winner       = IDX_W'(w_idx);
        winner_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_commit_arb.sv
// ============================================================================
// Module      : wb_commit_arb
// Description : Packet-locked round-robin writeback commit arbiter with a
//               registered output. WB_ARB_PERF_EN adds perf counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_arb
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64
) (
  input  logic             clk,
  input  logic             reset,
  wb_commit_arb_if.master  bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_packets
`endif
);

  localparam int IDX_W = WB_ARB_IDX_W(NUM_REQS);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_out_valid;
  logic [DATAW-1:0] r_out_data;
  logic             r_out_sop;
  logic             r_out_eop;
  logic [IDX_W-1:0] r_out_idx;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_valid;
  logic             w_can_load;
  logic             w_xfer;
  logic             w_win_eop;
  logic [IDX_W-1:0] w_next_ptr;

  wb_rr_picker #(.NUM_REQS(NUM_REQS)) u_picker (
    .valid        (bus.req_valid),
    .rr_ptr       (r_rr_ptr),
    .winner       (w_pick_idx),
    .winner_valid (w_pick_valid)
  );

  // While locked only the owner may proceed, even if it is idle this cycle.
  assign w_win_idx   = r_locked ? r_lock_idx : w_pick_idx;
  assign w_win_valid = r_locked ? bus.req_valid[r_lock_idx] : w_pick_valid;
  assign w_can_load  = !r_out_valid || bus.out_ready;
  assign w_xfer      = reset && w_can_load && w_win_valid;
  assign w_win_eop   = bus.req_eop[w_win_idx];
  assign w_next_ptr  = (w_win_idx == IDX_W'(NUM_REQS - 1)) ? '0
                                                            : w_win_idx + IDX_W'(1);

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_ready
    assign bus.req_ready[i] = w_xfer && (w_win_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_locked    <= 1'b0;
      r_lock_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.req_data[w_win_idx];
      r_out_sop   <= bus.req_sop[w_win_idx];
      r_out_eop   <= w_win_eop;
      r_out_idx   <= w_win_idx;
      if (w_win_eop) begin
        r_locked <= 1'b0;
        r_rr_ptr <= w_next_ptr;
      end else begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_win_idx;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_sop       = r_out_sop;
  assign bus.out_eop       = r_out_eop;
  assign bus.out_grant_idx = r_out_idx;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_packets;
  logic        w_stall;

  assign w_stall = |(bus.req_valid & ~bus.req_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall   <= '0;
      r_perf_packets <= '0;
    end else begin
      if (w_stall)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_xfer && w_win_eop)
        r_perf_packets <= r_perf_packets + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_packets      = r_perf_packets;
`endif

endmodule

`default_nettype wire

// File: doc/wb_commit_arb.md
# wb_commit_arb

Writeback commit arbiter for one issue slot. It merges the result streams of `NUM_REQS` execute units onto the single writeback port that feeds the issue stage's register file and scoreboard release. Grants rotate round-robin and are packet-locked: once a unit wins on a start-of-packet beat, it keeps the port until its end-of-packet beat, so multi-beat (sop/eop) results are never interleaved. The output is registered. One instance is used per `ISSUE_WIDTH` slot.

## Interface
Parameters:
- `NUM_REQS`, 4, number of execute-unit requesters (≥1)
- `DATAW`, 64, flattened writeback payload width (uuid, wis, tmask, PC, rd, data)

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `req_valid`  in  NUM_REQS  per-unit beat valid
- `req_data`  in  NUM_REQS×DATAW  per-unit payload
- `req_sop`  in  NUM_REQS  first beat of a packet
- `req_eop`  in  NUM_REQS  last beat of a packet
- `req_ready`  out  NUM_REQS  per-unit beat accepted
- `out_valid`  out  1  writeback beat valid
- `out_data`  out  DATAW  writeback payload
- `out_sop`  out  1  registered sop
- `out_eop`  out  1  registered eop
- `out_ready`  in  1  downstream accept; tied to 1 at integration if the consumer has no backpressure
- `out_grant_idx`  out  clog2(NUM_REQS) (min 1)  source unit of the current output beat

## Operation
- State: `rr_ptr` (highest-priority index), `locked`, `lock_idx`, and the output register (`out_valid`, `out_data`, `out_sop`, `out_eop`, `out_grant_idx`).
- `can_load = !out_valid || out_ready`.
- Unlocked: the winner is the first valid requester found scanning from `rr_ptr` upward, with wrap-around.
- Locked: the only candidate is `lock_idx`. Other requesters get no ready, even if `lock_idx` is idle.
- `req_ready[i] = can_load && winner_valid && (winner == i)`. At most one bit is set per cycle.
- A beat transfers when `req_valid[w] && req_ready[w]`. On transfer the output register loads the payload, sop, eop and `w`, and `out_valid` is set.
- If `out_ready` is high and no beat transfers, `out_valid` clears.
- Lock transitions on a transfer:
  - Non-eop beat: `locked←1`, `lock_idx←w`.
  - Eop beat: `locked←0`, `rr_ptr←(w+1) mod NUM_REQS`.
- Single-beat packets (sop=eop=1) never lock.
- A beat arriving while unlocked with sop=0 is accepted as the packet start. No error is flagged.
- Eop is the only lock-release event.

## Timing
- Latency: requester beat to `out_valid` is 1 cycle.
- Throughput: 1 beat per cycle while `out_ready=1`.
- Stall: while `out_valid && !out_ready`, all `req_ready` are 0 and the output register holds its value.
- No combinational path from `req_valid` to `out_valid`. `req_ready` depends combinationally on `out_ready`.
- Reset (asynchronous, any cycle, including mid-packet) forces:
  - `out_valid=0`, `out_sop=0`, `out_eop=0`, `out_data=0`, `out_grant_idx=0`
  - `rr_ptr=0`, `locked=0`, `lock_idx=0`
  - `req_ready=0` while reset is asserted
- Any packet in flight at reset is dropped. Requesters are re-arbitrated from index 0 after deassertion.
- `NUM_REQS=1`: pass-through register; the lock logic still operates.

## Configuration
- `WB_ARB_PERF_EN` defined adds two output ports:
  - `perf_stall_cycles` (32 bits): increments in every cycle where some `req_valid[i] && !req_ready[i]`.
  - `perf_packets` (32 bits): increments on every eop transfer.
  - Both reset to 0 and wrap at 2^32.
- `WB_ARB_PERF_EN` undefined: the ports and counters do not exist. Functional behaviour is identical.

## Structure
- Shared package (`VX_gpu_pkg`):
  - `WB_ARB_IDX_W` width helper
  - a `wb_beat_t` struct (data, sop, eop) used to flatten the payload
- Sub-module `wb_rr_picker`: combinational rotate-priority encoder. Inputs are the valid vector and `rr_ptr`; outputs are winner index and winner valid.
- The lock, output register and perf counters stay in `wb_commit_arb`.

## Test plan
- Units 0,1,2,3 all valid, single-beat, `out_ready=1`, after reset → `out_grant_idx` is 0,1,2,3,0 on consecutive cycles, first `out_valid` 1 cycle after the first request.
- Unit 1 sends 3 beats (sop, –, eop) while unit 2 is continuously valid → the three unit-1 beats appear back-to-back and `req_ready[2]=0` until the cycle after unit-1 eop transfers; then unit 2 wins.
- `out_valid=1` with `out_ready=0` for 4 cycles → `out_data` is stable, all `req_ready` are 0; on release, the next beat appears 1 cycle later.
- Locked on unit 3 mid-packet, `reset` driven to 0 → `out_valid` is 0 immediately; after release, unit 0 wins first with unit 0 and unit 3 valid.
- Unit 2 locked, idle for 5 cycles while unit 0 is valid → unit 0 is never granted until unit 2 sends eop.
- With `WB_ARB_PERF_EN`: the stall scenario above with a second requester waiting → `perf_stall_cycles` increases by 4 and `perf_packets` counts each eop exactly once.
